// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder: one GROUP-bit lookahead group is resolved per stage, group carry registered between stages.
// Optional signed-overflow output enabled by defining CLA_ADDER_PIPE_OVF_EN.
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CLA_ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int  GSAFE  = (GROUP > 0) ? GROUP : 1;
  localparam int  NG     = (GROUP > 0 && WIDTH >= GROUP) ? WIDTH / GROUP : 1;
  localparam bit  CFG_OK = (GROUP >= 1) && (WIDTH >= GROUP) && ((WIDTH % GSAFE) == 0);

  if (!CFG_OK) begin : g_bad_cfg
    $error("cla_adder_pipe: WIDTH must be a positive multiple of GROUP (GROUP >= 1)");
  end

  // Returns {carry into group MSB, group carry-out, group sum}; every carry is a flat sum of products.
  function automatic logic [GROUP+1:0] cla_group(input logic [GROUP-1:0] ga,
                                                 input logic [GROUP-1:0] gb,
                                                 input logic             ci);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             cc;
    logic             t;
    p    = ga ^ gb;
    g    = ga & gb;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      cc = ci;
      for (int j = 0; j <= i; j++) cc = cc & p[j];
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        cc = cc | t;
      end
      c[i+1] = cc;
    end
    return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // Resolved groups enter at the top and shift down, so after NG stages group 0 sits at bit 0.
  function automatic logic [WIDTH-1:0] place(input logic [GROUP-1:0] gs,
                                             input logic [WIDTH-1:0] prev);
    return (prev >> GROUP) | (WIDTH'(gs) << (WIDTH - GROUP));
  endfunction

  logic [NG-1:0]    vld_p;
  logic [WIDTH-1:0] opa_p [NG];
  logic [WIDTH-1:0] opb_p [NG];
  logic [WIDTH-1:0] sum_p [NG];
  logic [NG-1:0]    cy_p;
  logic [GROUP+1:0] grp   [NG];
  logic             adv;

  assign out_valid = vld_p[NG-1];
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign s         = sum_p[NG-1];
  assign cout      = cy_p[NG-1];

  // Stage 0 resolves group 0 straight from the ports; stage k resolves group k from stage k-1.
  always_comb begin
    grp[0] = cla_group(a[GROUP-1:0], b[GROUP-1:0], cin);
    for (int k = 1; k < NG; k++) begin
      grp[k] = cla_group(opa_p[k-1][GROUP-1:0], opb_p[k-1][GROUP-1:0], cy_p[k-1]);
    end
  end

`ifdef CLA_ADDER_PIPE_OVF_EN
  logic ovf_p;
  assign ovf = ovf_p;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p        <= '0;
      sum_p[NG-1]  <= '0;
      cy_p[NG-1]   <= 1'b0;
`ifdef CLA_ADDER_PIPE_OVF_EN
      ovf_p        <= 1'b0;
`endif
    end else if (adv) begin
      vld_p[0] <= in_valid;
      opa_p[0] <= a >> GROUP;
      opb_p[0] <= b >> GROUP;
      sum_p[0] <= place(grp[0][GROUP-1:0], '0);
      cy_p[0]  <= grp[0][GROUP];
      for (int k = 1; k < NG; k++) begin
        vld_p[k] <= vld_p[k-1];
        opa_p[k] <= opa_p[k-1] >> GROUP;
        opb_p[k] <= opb_p[k-1] >> GROUP;
        sum_p[k] <= place(grp[k][GROUP-1:0], sum_p[k-1]);
        cy_p[k]  <= grp[k][GROUP];
      end
`ifdef CLA_ADDER_PIPE_OVF_EN
      ovf_p <= grp[NG-1][GROUP+1] ^ grp[NG-1][GROUP];
`endif
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: 16/4 and 32/8 instances against a plain a+b+cin reference with a result queue.
module tb_cla_adder_pipe;
  localparam int W  = 16;
  localparam int WW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0]  a, b, s;
  logic          w_in_valid, w_in_ready, w_cin, w_out_valid, w_out_ready, w_cout;
  logic [WW-1:0] w_a, w_b, w_s;
`ifdef CLA_ADDER_PIPE_OVF_EN
  logic ovf, w_ovf;
`endif

  cla_adder_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout)
`ifdef CLA_ADDER_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  cla_adder_pipe #(.WIDTH(WW), .GROUP(8)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b), .cin(w_cin),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .s(w_s), .cout(w_cout)
`ifdef CLA_ADDER_PIPE_OVF_EN
    , .ovf(w_ovf)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic          acc, hs, w_acc, w_hs;
  logic [W-1:0]  hs_s;
  logic          hs_cout, w_hs_cout;
  logic [WW-1:0] w_hs_s;
  logic [W:0]    q16[$];
  logic [WW:0]   q32[$];

  // Settle, record this cycle's handshakes and presented result, then cross the next rising edge.
  task automatic tick;
    #1;
    acc       = in_valid && in_ready && !rst;
    hs        = out_valid && out_ready && !rst;
    hs_s      = s;
    hs_cout   = cout;
    w_acc     = w_in_valid && w_in_ready && !rst;
    w_hs      = w_out_valid && w_out_ready && !rst;
    w_hs_s    = w_s;
    w_hs_cout = w_cout;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int seen;
    seen = 0;
    rst = 1'b1; in_valid = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0; out_ready = 1'b1;
    tick;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready); end
    tick;
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || s !== 16'h0 || cout !== 1'b0)
    begin bad++; $display("FAIL reset_state: got vld=%b s=%h c=%b want 0 0000 0", out_valid, s, cout); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      if (out_valid === 1'b1) seen++;
      tick;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_beat_discarded: got %0d outputs want 0", seen); end
  endtask

  task automatic test_single;
    out_ready = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    tick;
    in_valid = 1'b0;
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL single_accept: got %b want 1", acc); end
    for (int i = 1; i <= 6; i++) begin
      total++;
      if (out_valid !== (i == 4)) begin bad++; $display("FAIL single_latency cyc%0d: got vld=%b want %b", i, out_valid, (i == 4)); end
      if (i == 4) begin
        total++;
        if (s !== 16'h0000 || cout !== 1'b1)
        begin bad++; $display("FAIL single_result: got s=%h c=%b want 0000 1", s, cout); end
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int got, first, last;
    logic [W:0] e;
    got = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; a = W'(c); b = W'(c * 32'h1000); cin = c[0];
      end else in_valid = 1'b0;
      tick;
      if (acc) q16.push_back({1'b0, a} + {1'b0, b} + cin);
      if (hs) begin
        total++;
        if (q16.size() == 0) begin bad++; $display("FAIL b2b_unexpected: got s=%h want none", hs_s); end
        else begin
          e = q16.pop_front();
          if ({hs_cout, hs_s} !== e) begin bad++; $display("FAIL b2b_result: got %h want %h", {hs_cout, hs_s}, e); end
        end
        if (first < 0) first = c;
        last = c; got++;
      end
    end
    total++;
    if (got !== 8 || last - first !== 7)
    begin bad++; $display("FAIL b2b_stream: got %0d results over %0d cycles want 8 over 8", got, last - first + 1); end
  endtask

  task automatic test_backpressure;
    int j, got;
    logic [W-1:0] held;
    logic stable;
    logic [W:0] e;
    j = 0; got = 0; stable = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (j < 6) begin
        in_valid = 1'b1; a = W'(32'h0100 * (j + 1) + j); b = W'(32'h0011 * j + 32'hF000); cin = j[0];
      end else in_valid = 1'b0;
      tick;
      if (acc) begin q16.push_back({1'b0, a} + {1'b0, b} + cin); j++; end
    end
    total++;
    if (j !== 4) begin bad++; $display("FAIL bp_accepted: got %0d want 4", j); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    held = s;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (s !== held || out_valid !== 1'b1) stable = 1'b0;
    end
    total++;
    if (stable !== 1'b1) begin bad++; $display("FAIL bp_stable: got s=%h want %h", s, held); end
    out_ready = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (hs) begin
        got++;
        total++;
        if (q16.size() == 0) begin bad++; $display("FAIL bp_unexpected: got s=%h want none", hs_s); end
        else begin
          e = q16.pop_front();
          if ({hs_cout, hs_s} !== e) begin bad++; $display("FAIL bp_result: got %h want %h", {hs_cout, hs_s}, e); end
        end
      end
    end
    total++;
    if (got !== 4 || in_ready !== 1'b1)
    begin bad++; $display("FAIL bp_drain: got %0d results rdy=%b want 4 rdy=1", got, in_ready); end
  endtask

  task automatic test_reset_midflight;
    int outs, at;
    outs = 0; at = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; a = W'(32'h1111 * (c + 1)); b = W'(32'h0101); cin = 1'b1;
      tick;
    end
    in_valid = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    q16.delete();
    total++;
    if (out_valid !== 1'b0 || s !== 16'h0 || cout !== 1'b0)
    begin bad++; $display("FAIL midrst_state: got vld=%b s=%h c=%b want 0 0000 0", out_valid, s, cout); end
    in_valid = 1'b1; a = 16'h0003; b = 16'h0004; cin = 1'b0;
    tick;
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (out_valid === 1'b1) begin
        outs++; at = i;
        total++;
        if (s !== 16'h0007 || cout !== 1'b0) begin bad++; $display("FAIL midrst_result: got s=%h c=%b want 0007 0", s, cout); end
      end
      tick;
    end
    total++;
    if (outs !== 1 || at !== 4) begin bad++; $display("FAIL midrst_count: got %0d outputs at cyc %0d want 1 at 4", outs, at); end
  endtask

`ifdef CLA_ADDER_PIPE_OVF_EN
  task automatic test_ovf;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
    tick;
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
    tick;
    in_valid = 1'b0;
    tick; tick;
    total++;
    if (out_valid !== 1'b1 || s !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1)
    begin bad++; $display("FAIL ovf_pos: got vld=%b s=%h c=%b o=%b want 1 8000 0 1", out_valid, s, cout, ovf); end
    tick;
    total++;
    if (out_valid !== 1'b1 || s !== 16'hFFFE || cout !== 1'b1 || ovf !== 1'b0)
    begin bad++; $display("FAIL ovf_neg: got vld=%b s=%h c=%b o=%b want 1 FFFE 1 0", out_valid, s, cout, ovf); end
    tick; tick; tick; tick;
  endtask
`endif

  task automatic test_random;
    logic [W:0] e;
    in_valid = 1'b0; acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(3) != 0);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(1));
      end
      out_ready = ($urandom_range(9) < 7);
      tick;
      if (acc) q16.push_back({1'b0, a} + {1'b0, b} + cin);
      if (hs) begin
        total++;
        if (q16.size() == 0) begin bad++; $display("FAIL rand16_unexpected: got s=%h want none", hs_s); end
        else begin
          e = q16.pop_front();
          if ({hs_cout, hs_s} !== e) begin bad++; $display("FAIL rand16_result: got %h want %h", {hs_cout, hs_s}, e); end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (hs) begin
        total++;
        if (q16.size() == 0) begin bad++; $display("FAIL rand16_unexpected: got s=%h want none", hs_s); end
        else begin
          e = q16.pop_front();
          if ({hs_cout, hs_s} !== e) begin bad++; $display("FAIL rand16_result: got %h want %h", {hs_cout, hs_s}, e); end
        end
      end
    end
    total++;
    if (q16.size() != 0) begin bad++; $display("FAIL rand16_drain: got %0d pending want 0", q16.size()); end
  endtask

  task automatic test_wide;
    int n_acc, cyc;
    logic [WW:0] e;
    w_out_ready = 1'b1; w_in_valid = 1'b1; w_a = 32'hFFFF_FFFF; w_b = 32'h0; w_cin = 1'b1;
    tick;
    w_in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      total++;
      if (w_out_valid !== (i == 4)) begin bad++; $display("FAIL wide_latency cyc%0d: got vld=%b want %b", i, w_out_valid, (i == 4)); end
      if (i == 4) begin
        total++;
        if (w_s !== 32'h0 || w_cout !== 1'b1) begin bad++; $display("FAIL wide_carry: got s=%h c=%b want 00000000 1", w_s, w_cout); end
      end
      tick;
    end
    n_acc = 0; cyc = 0; w_acc = 1'b0;
    while (n_acc < 1000 && cyc < 6000) begin
      if (!w_in_valid || w_acc) begin
        w_in_valid = ($urandom_range(7) != 0);
        w_a = $urandom; w_b = $urandom; w_cin = 1'($urandom_range(1));
      end
      w_out_ready = ($urandom_range(7) != 0);
      tick;
      cyc++;
      if (w_acc) begin q32.push_back({1'b0, w_a} + {1'b0, w_b} + w_cin); n_acc++; end
      if (w_hs) begin
        total++;
        if (q32.size() == 0) begin bad++; $display("FAIL rand32_unexpected: got s=%h want none", w_hs_s); end
        else begin
          e = q32.pop_front();
          if ({w_hs_cout, w_hs_s} !== e) begin bad++; $display("FAIL rand32_result: got %h want %h", {w_hs_cout, w_hs_s}, e); end
        end
      end
    end
    total++;
    if (n_acc !== 1000) begin bad++; $display("FAIL rand32_budget: got %0d beats want 1000", n_acc); end
    w_in_valid = 1'b0; w_out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (w_hs) begin
        total++;
        if (q32.size() == 0) begin bad++; $display("FAIL rand32_unexpected: got s=%h want none", w_hs_s); end
        else begin
          e = q32.pop_front();
          if ({w_hs_cout, w_hs_s} !== e) begin bad++; $display("FAIL rand32_result: got %h want %h", {w_hs_cout, w_hs_s}, e); end
        end
      end
    end
    total++;
    if (q32.size() != 0) begin bad++; $display("FAIL rand32_drain: got %0d pending want 0", q32.size()); end
  endtask

  initial begin
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_out_ready = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
`ifdef CLA_ADDER_PIPE_OVF_EN
    test_ovf;
`endif
    test_random;
    test_wide;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
